// File: rtl/forward_hazard_ctrl_if.sv
// Pipeline-side signal bundle for the forwarding/hazard controller.
// The master drives ID/EX status into the controller; the slave returns the selects and stalls.
interface forward_hazard_ctrl_if;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [4:0]  RdD;
    logic        RegWriteD;
    logic        LoadD;
    logic        PCSrcE;
    logic        MemWait;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic        StallF;
    logic        StallD;
    logic        StallEMW;
    logic        FlushD;
    logic        FlushE;
    logic [15:0] StallCount;

    modport master (
        output Rs1D, Rs2D, RdD, RegWriteD, LoadD, PCSrcE, MemWait,
        input  ForwardAE, ForwardBE, StallF, StallD, StallEMW, FlushD, FlushE, StallCount
    );

    modport slave (
        input  Rs1D, Rs2D, RdD, RegWriteD, LoadD, PCSrcE, MemWait,
        output ForwardAE, ForwardBE, StallF, StallD, StallEMW, FlushD, FlushE, StallCount
    );
endinterface

// File: rtl/forward_hazard_ctrl.sv
// Forwarding and hazard control for a 5-stage pipeline, tracking E/M/W in a shadow pipeline.
// Produces EX operand forward selects, stall/flush controls and a saturating load-use counter.
module forward_hazard_ctrl (
    input  logic                  clk,
    input  logic                  reset,
    forward_hazard_ctrl_if.slave  bus_if
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       load;
    } stage_t;

    localparam stage_t Bubble = '0;

    stage_t      e_q, e_d, m_q, m_d, w_q, w_d;
    logic [4:0]  rs1e_q, rs1e_d, rs2e_q, rs2e_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic        lw_stall;

    // MEM result wins over WB; x0 never matches.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input stage_t m,
                                           input stage_t w);
        if (m.valid && m.regwrite && (m.rd != 5'd0) && (m.rd == rs)) return 2'b10;
        if (w.valid && w.regwrite && (w.rd != 5'd0) && (w.rd == rs)) return 2'b01;
        return 2'b00;
    endfunction

    assign lw_stall = e_q.valid && e_q.load && (e_q.rd != 5'd0) &&
                      ((e_q.rd == bus_if.Rs1D) || (e_q.rd == bus_if.Rs2D));

    assign bus_if.ForwardAE  = fwd_sel(rs1e_q, m_q, w_q);
    assign bus_if.ForwardBE  = fwd_sel(rs2e_q, m_q, w_q);
    assign bus_if.StallCount = stall_count_q;

    always_comb begin
        bus_if.StallF   = 1'b0;
        bus_if.StallD   = 1'b0;
        bus_if.StallEMW = 1'b0;
        bus_if.FlushD   = 1'b0;
        bus_if.FlushE   = 1'b0;
        e_d             = e_q;
        m_d             = m_q;
        w_d             = w_q;
        rs1e_d          = rs1e_q;
        rs2e_d          = rs2e_q;
        stall_count_d   = stall_count_q;

        if (bus_if.MemWait) begin
            bus_if.StallF   = 1'b1;
            bus_if.StallD   = 1'b1;
            bus_if.StallEMW = 1'b1;
        end else if (bus_if.PCSrcE) begin
            bus_if.FlushD = 1'b1;
            bus_if.FlushE = 1'b1;
            e_d           = Bubble;
            rs1e_d        = 5'd0;
            rs2e_d        = 5'd0;
            m_d           = e_q;
            w_d           = m_q;
        end else if (lw_stall) begin
            bus_if.StallF = 1'b1;
            bus_if.StallD = 1'b1;
            bus_if.FlushE = 1'b1;
            e_d           = Bubble;
            rs1e_d        = 5'd0;
            rs2e_d        = 5'd0;
            m_d           = e_q;
            w_d           = m_q;
            if (stall_count_q != 16'hFFFF) stall_count_d = stall_count_q + 16'd1;
        end else begin
            e_d    = '{valid: 1'b1, rd: bus_if.RdD, regwrite: bus_if.RegWriteD,
                       load: bus_if.LoadD};
            rs1e_d = bus_if.Rs1D;
            rs2e_d = bus_if.Rs2D;
            m_d    = e_q;
            w_d    = m_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q           <= Bubble;
            m_q           <= Bubble;
            w_q           <= Bubble;
            rs1e_q        <= 5'd0;
            rs2e_q        <= 5'd0;
            stall_count_q <= 16'd0;
        end else begin
            e_q           <= e_d;
            m_q           <= m_d;
            w_q           <= w_d;
            rs1e_q        <= rs1e_d;
            rs2e_q        <= rs2e_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Scoreboard bench for forward_hazard_ctrl: expected output vectors are queued as each
// cycle is driven and compared against the observed outputs captured mid-cycle.
module tb_forward_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    forward_hazard_ctrl_if bus_if ();

    forward_hazard_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus_if.slave)
    );

    typedef struct {
        string       name;
        logic [24:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    logic [24:0] obs_q[$];
    int          checks = 0;
    int          errors = 0;

    // {ForwardAE, ForwardBE, StallF, StallD, StallEMW, FlushD, FlushE, StallCount}
    function automatic logic [24:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic sf, input logic sd, input logic semw,
                                       input logic fd, input logic fe, input logic [15:0] cnt);
        return {fa, fb, sf, sd, semw, fd, fe, cnt};
    endfunction

    // Entered at a negedge: drive, queue expectation, sample 1 ns later, return at next negedge.
    task automatic cyc(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic pc, input logic mw,
                       input string nm, input logic [24:0] e);
        sb_t s;
        bus_if.Rs1D      = rs1;
        bus_if.Rs2D      = rs2;
        bus_if.RdD       = rd;
        bus_if.RegWriteD = rw;
        bus_if.LoadD     = ld;
        bus_if.PCSrcE    = pc;
        bus_if.MemWait   = mw;
        s.name = nm;
        s.exp  = e;
        sb_q.push_back(s);
        #1;
        obs_q.push_back({bus_if.ForwardAE, bus_if.ForwardBE, bus_if.StallF, bus_if.StallD,
                         bus_if.StallEMW, bus_if.FlushD, bus_if.FlushE, bus_if.StallCount});
        @(negedge clk);
    endtask

    task automatic nop(input string nm, input logic [24:0] e);
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, nm, e);
    endtask

    task automatic test_reset();
        sb_t s;
        logic [24:0] o;
        reset = 1'b1;
        bus_if.Rs1D = '0; bus_if.Rs2D = '0; bus_if.RdD = '0;
        bus_if.RegWriteD = 1'b0; bus_if.LoadD = 1'b0; bus_if.PCSrcE = 1'b0; bus_if.MemWait = 1'b0;
        repeat (2) @(negedge clk);
        nop("rst_held", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h0000));
        reset = 1'b0;
        nop("rst_released", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h0000));
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== s.exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b", s.name, o, s.exp);
            end
        end
    endtask

    task automatic test_alu_forward();
        sb_t s;
        logic [24:0] o;
        cyc(5'd1, 5'd2, 5'd5, 1, 0, 0, 0, "alu_add", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h0));
        cyc(5'd5, 5'd1, 5'd6, 1, 0, 0, 0, "alu_sub", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h0));
        cyc(5'd3, 5'd5, 5'd7, 1, 0, 0, 0, "alu_fwd_mem", ev(2'b10, 2'b00, 0, 0, 0, 0, 0, 16'h0));
        nop("alu_fwd_wb", ev(2'b00, 2'b01, 0, 0, 0, 0, 0, 16'h0));
        nop("alu_drain", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h0));
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== s.exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b", s.name, o, s.exp);
            end
        end
    endtask

    task automatic test_mem_wb_same_rd();
        sb_t s;
        logic [24:0] o;
        cyc(5'd1, 5'd2, 5'd5, 1, 0, 0, 0, "mw_first", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h0));
        cyc(5'd3, 5'd0, 5'd5, 1, 0, 0, 0, "mw_second", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h0));
        cyc(5'd5, 5'd5, 5'd9, 1, 0, 0, 0, "mw_rs2_x0", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h0));
        nop("mw_mem_prio", ev(2'b10, 2'b10, 0, 0, 0, 0, 0, 16'h0));
        nop("mw_drain", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h0));
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== s.exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b", s.name, o, s.exp);
            end
        end
    endtask

    task automatic test_load_use();
        sb_t s;
        logic [24:0] o;
        cyc(5'd1, 5'd0, 5'd7, 1, 1, 0, 0, "lu_lw", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h0));
        cyc(5'd7, 5'd7, 5'd8, 1, 0, 0, 0, "lu_stall", ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 16'h0));
        cyc(5'd7, 5'd7, 5'd8, 1, 0, 0, 0, "lu_bubble", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h1));
        nop("lu_fwd_wb", ev(2'b01, 2'b01, 0, 0, 0, 0, 0, 16'h1));
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== s.exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b", s.name, o, s.exp);
            end
        end
    endtask

    task automatic test_branch();
        sb_t s;
        logic [24:0] o;
        cyc(5'd1, 5'd0, 5'd10, 1, 1, 0, 0, "br_lw", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h1));
        cyc(5'd10, 5'd0, 5'd11, 1, 0, 1, 0, "br_wins", ev(2'b00, 2'b00, 0, 0, 0, 1, 1, 16'h1));
        nop("br_after", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h1));
        cyc(5'd0, 5'd0, 5'd0, 0, 0, 1, 1, "br_memwait", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 16'h1));
        cyc(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, "br_released", ev(2'b00, 2'b00, 0, 0, 0, 1, 1, 16'h1));
        nop("br_drain", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h1));
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== s.exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b", s.name, o, s.exp);
            end
        end
    endtask

    task automatic test_memwait_load_use();
        sb_t s;
        logic [24:0] o;
        cyc(5'd0, 5'd0, 5'd12, 1, 1, 0, 0, "mwl_lw", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h1));
        for (int i = 0; i < 3; i++)
            cyc(5'd12, 5'd0, 5'd13, 1, 0, 0, 1, "mwl_hold",
                ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 16'h1));
        cyc(5'd12, 5'd0, 5'd13, 1, 0, 0, 0, "mwl_stall", ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 16'h1));
        cyc(5'd12, 5'd0, 5'd13, 1, 0, 0, 0, "mwl_bubble", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h2));
        nop("mwl_fwd", ev(2'b01, 2'b00, 0, 0, 0, 0, 0, 16'h2));
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== s.exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b", s.name, o, s.exp);
            end
        end
    endtask

    task automatic test_x0_saturation();
        sb_t s;
        logic [24:0] o;
        cyc(5'd1, 5'd2, 5'd0, 1, 0, 0, 0, "x0_wr", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h2));
        cyc(5'd0, 5'd0, 5'd3, 1, 0, 0, 0, "x0_use", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h2));
        cyc(5'd0, 5'd0, 5'd0, 1, 1, 0, 0, "x0_nofwd", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h2));
        cyc(5'd0, 5'd0, 5'd4, 1, 0, 0, 0, "x0_nostall", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h2));
        nop("x0_drain", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h2));
        // Preload the counter; the next edge reloads it from the forced value.
        force dut.stall_count_q = 16'hFFFE;
        nop("sat_preload", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'hFFFE));
        release dut.stall_count_q;
        cyc(5'd7, 5'd0, 5'd7, 0, 1, 0, 0, "sat_lw", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'hFFFE));
        cyc(5'd7, 5'd0, 5'd7, 0, 1, 0, 0, "sat_s1", ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 16'hFFFE));
        cyc(5'd7, 5'd0, 5'd7, 0, 1, 0, 0, "sat_b1", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'hFFFF));
        cyc(5'd7, 5'd0, 5'd7, 0, 1, 0, 0, "sat_s2", ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 16'hFFFF));
        cyc(5'd7, 5'd0, 5'd7, 0, 1, 0, 0, "sat_b2", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'hFFFF));
        cyc(5'd7, 5'd0, 5'd7, 0, 1, 0, 0, "sat_s3", ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 16'hFFFF));
        nop("sat_held", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'hFFFF));
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== s.exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b", s.name, o, s.exp);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        sb_t s;
        logic [24:0] o;
        cyc(5'd7, 5'd0, 5'd7, 0, 1, 0, 0, "rms_lw", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'hFFFF));
        reset = 1'b1;
        cyc(5'd7, 5'd0, 5'd7, 0, 1, 0, 1, "rms_wait", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 16'hFFFF));
        reset = 1'b0;
        cyc(5'd7, 5'd0, 5'd7, 0, 1, 0, 0, "rms_cleared", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h0));
        nop("rms_idle", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h0));
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== s.exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b", s.name, o, s.exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_forward();
        test_mem_wb_same_rd();
        test_load_use();
        test_branch();
        test_memwait_load_use();
        test_x0_saturation();
        test_reset_mid_stall();
        if (obs_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_leftover: got %0d extra samples expected 0", obs_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/forward_hazard_ctrl.md
FORWARD_HAZARD_CTRL -- requirements
Module: forward_hazard_ctrl

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  single rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- Rs1D  input  5  ID-stage source register 1.
- Rs2D  input  5  ID-stage source register 2.
- RdD  input  5  ID-stage destination register.
- RegWriteD  input  1  ID-stage instruction writes the register file.
- LoadD  input  1  ID-stage instruction is a load (result from data memory).
- PCSrcE  input  1  branch/jump in EX taken this cycle.
- MemWait  input  1  data memory not ready; whole pipeline holds.
- ForwardAE  output  2  select for the EX operand-A 3:1 mux.
- ForwardBE  output  2  select for the EX operand-B 3:1 mux.
- StallF  output  1  hold the PC register.
- StallD  output  1  hold the IF/ID register.
- StallEMW  output  1  hold the ID/EX, EX/MEM and MEM/WB registers.
- FlushD  output  1  clear the IF/ID register.
- FlushE  output  1  clear the ID/EX register.
- StallCount  output  16  saturating count of load-use bubbles.
REQ-002 Forward select encoding SHALL be: 00 = register file, 01 = WB result, 10 = MEM ALU result; 11 SHALL never be driven.

Function
REQ-003 The block SHALL keep an internal shadow pipeline (stage E, stage M, stage W) with fields {valid, rd, regwrite, load}, plus Rs1E and Rs2E for stage E.
REQ-004 On a normal advance, D inputs SHALL move to E, E to M, and M to W at the clk edge.
REQ-005 ForwardAE SHALL be 10 when M.valid, M.regwrite, M.rd != 0 and M.rd == Rs1E.
REQ-006 Otherwise ForwardAE SHALL be 01 when W.valid, W.regwrite, W.rd != 0 and W.rd == Rs1E.
REQ-007 Otherwise ForwardAE SHALL be 00.
REQ-008 ForwardBE SHALL follow the rules of REQ-005 to REQ-007 using Rs2E.
REQ-009 ForwardAE and ForwardBE SHALL be combinational from the registered shadow state, with MEM priority over WB.
REQ-010 Load-use hazard (lwStall) SHALL be: E.valid, E.load, E.rd != 0, and (E.rd == Rs1D or E.rd == Rs2D).
REQ-011 On lwStall: StallF = StallD = FlushE = 1, stage E SHALL load a bubble (valid = 0) at the next edge, and E SHALL advance into M.
REQ-012 On PCSrcE: FlushD = FlushE = 1, and stage E SHALL load a bubble at the next edge.
REQ-013 When PCSrcE and lwStall are both true, PCSrcE SHALL win: StallF = StallD = 0 and FlushD = FlushE = 1.
REQ-014 When MemWait = 1: StallF = StallD = StallEMW = 1, FlushD = FlushE = 0, all shadow state SHALL hold, and StallCount SHALL NOT increment.
REQ-015 MemWait SHALL take priority over PCSrcE and lwStall.
REQ-016 A branch taken while MemWait = 1 SHALL be acted on (per REQ-012) in the first cycle after MemWait deasserts, because PCSrcE is held by the stalled ID/EX register.
REQ-017 StallCount SHALL increment by 1 on each edge where lwStall = 1, PCSrcE = 0 and MemWait = 0.
REQ-018 StallCount SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-019 Register x0 SHALL never cause forwarding or a stall.

Reset
REQ-020 While reset = 1 at a clk edge, all shadow valid bits, rd fields, Rs1E, Rs2E and StallCount SHALL clear to 0.
REQ-021 After reset, outputs SHALL be: ForwardAE = ForwardBE = 00, and StallF, StallD, StallEMW, FlushD, FlushE all 0, with MemWait = PCSrcE = 0.
REQ-022 Reset asserted mid-stall or mid-flush SHALL discard all in-flight shadow state within one edge.
REQ-023 Reset SHALL have priority over MemWait.

Verification
REQ-024 Back-to-back ALU hazard: issue add x5; then sub x6,x5,x1 one cycle later -> ForwardAE = 10 in the sub's EX cycle; issue a third instruction using x5 two cycles after the add -> Forward = 01.
REQ-025 MEM/WB same rd: x5 written by both the M and W stages, Rs1E = 5 -> ForwardAE = 10.
REQ-026 Load-use: lw x7 followed by add x8,x7,x7 -> one cycle with StallF = StallD = FlushE = 1, then ForwardAE = ForwardBE = 01, and StallCount = 1.
REQ-027 Taken branch with lwStall in the same cycle: PCSrcE = 1 -> FlushD = FlushE = 1, StallF = 0, and StallCount unchanged.
REQ-028 MemWait held 3 cycles during a pending load-use -> StallEMW = 1 for 3 cycles, no flush, StallCount unchanged; the stall resolves after MemWait drops.
REQ-029 x0 writes and saturation: writes to x0 -> Forward = 00; StallCount preloaded to 16'hFFFE plus 3 bubbles -> StallCount = 16'hFFFF; reset mid-stall -> all outputs 0 on the next cycle.
